// File: rtl/sdram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bus_arbiter
// Function : Round-robin share of the SDRAM controller bus port among N masters
// Revision : 1.0
// ============================================================================
module sdram_bus_arbiter #(
  parameter int N  = 2,
  parameter int DW = 16,
  parameter int AW = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           m_read,
  input  logic [N-1:0]           m_write,
  input  logic [N*AW-1:0]        m_addr,
  input  logic [N-1:0]           m_burst,
  input  logic [N*3-1:0]         m_burst_len,
  input  logic [N*DW-1:0]        m_wdata,
  input  logic [N*2-1:0]         m_byteenable,
  output logic [N-1:0]           m_ready,
  output logic [N-1:0]           m_rvalid,
  output logic [DW-1:0]          m_rdata,
  output logic                   bus_read,
  output logic                   bus_write,
  output logic [AW-1:0]          bus_addr,
  output logic                   bus_burst,
  output logic [2:0]             bus_burst_len,
  output logic [DW-1:0]          bus_wdata,
  output logic [1:0]             bus_byteenable,
  input  logic                   bus_ready,
  input  logic                   bus_rvalid,
  input  logic [DW-1:0]          bus_rdata,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   stray_rvalid
);

  localparam int OW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WDATA = 2'd2,
    S_RWAIT = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt;
  logic [OW-1:0] r_last, w_last_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_stray;

  logic [N-1:0]  w_req;
  logic [OW-1:0] w_winner;
  int            w_idx;

  logic          w_rd, w_wr, w_burst;
  logic [AW-1:0] w_addr;
  logic [2:0]    w_len;
  logic [DW-1:0] w_wdata;
  logic [1:0]    w_be;
  logic [3:0]    w_beats;

  assign w_req   = m_read | m_write;
  assign w_rd    = m_read[r_owner];
  assign w_wr    = m_write[r_owner];
  assign w_burst = m_burst[r_owner];
  assign w_addr  = m_addr[r_owner*AW +: AW];
  assign w_len   = m_burst_len[r_owner*3 +: 3];
  assign w_wdata = m_wdata[r_owner*DW +: DW];
  assign w_be    = m_byteenable[r_owner*2 +: 2];

  assign owner        = r_owner;
  assign stray_rvalid = r_stray;
  assign m_rdata      = bus_rdata;

  always_comb begin
    w_beats = 4'd1;
    if (w_burst) begin
      case (w_len)
        3'd0:    w_beats = 4'd1;
        3'd1:    w_beats = 4'd2;
        3'd2:    w_beats = 4'd4;
        default: w_beats = 4'd8;
      endcase
    end
  end

  // Scan downward so the requester closest after r_last is the final assignment.
  always_comb begin
    w_winner = r_last;
    w_idx    = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (w_req[w_idx]) w_winner = OW'(w_idx);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_addr       = '0;
    bus_burst      = 1'b0;
    bus_burst_len  = '0;
    bus_wdata      = '0;
    bus_byteenable = '0;
    m_ready        = '0;
    m_rvalid       = '0;
    if (r_state != S_IDLE) begin
      bus_addr       = w_addr;
      bus_burst      = w_burst;
      bus_burst_len  = w_len;
      bus_wdata      = w_wdata;
      bus_byteenable = w_be;
    end
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        bus_write = w_wr;
        bus_read  = w_rd & ~w_wr;
        m_ready[r_owner] = bus_ready & (w_wr | w_rd);
        if (!(w_wr | w_rd)) begin
          w_state_nxt = S_IDLE;
        end else if (bus_ready) begin
          if (w_wr) begin
            w_cnt_nxt   = w_beats - 4'd1;
            w_state_nxt = (w_beats == 4'd1) ? S_IDLE : S_WDATA;
          end else begin
            w_cnt_nxt   = w_beats;
            w_state_nxt = S_RWAIT;
          end
        end
      end
      S_WDATA: begin
        bus_write        = w_wr;
        m_ready[r_owner] = bus_ready & w_wr;
        if (bus_ready && w_wr) begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = S_IDLE;
        end
      end
      S_RWAIT: begin
        m_rvalid[r_owner] = bus_rvalid;
        if (bus_rvalid) begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= OW'(N - 1);
      r_cnt   <= '0;
      r_stray <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      if (bus_rvalid && r_state != S_RWAIT) r_stray <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_bus_arbiter
// Function : Directed scenarios plus randomized traffic against a transaction model
// Revision : 1.0
// ============================================================================
module tb_sdram_bus_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int OW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_read, m_write, m_burst;
  logic [N*AW-1:0]   m_addr;
  logic [N*3-1:0]    m_burst_len;
  logic [N*DW-1:0]   m_wdata;
  logic [N*2-1:0]    m_byteenable;
  logic [N-1:0]      m_ready, m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic              bus_read, bus_write, bus_burst;
  logic [AW-1:0]     bus_addr;
  logic [2:0]        bus_burst_len;
  logic [DW-1:0]     bus_wdata;
  logic [1:0]        bus_byteenable;
  logic              bus_ready, bus_rvalid;
  logic [DW-1:0]     bus_rdata;
  logic [OW-1:0]     owner;
  logic              stray_rvalid;

  int checks = 0;
  int errors = 0;

  sdram_bus_arbiter #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_burst(m_burst),
    .m_burst_len(m_burst_len), .m_wdata(m_wdata), .m_byteenable(m_byteenable),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_burst(bus_burst), .bus_burst_len(bus_burst_len), .bus_wdata(bus_wdata),
    .bus_byteenable(bus_byteenable), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .owner(owner), .stray_rvalid(stray_rvalid)
  );

  always #5 clk = ~clk;

  function automatic int beats_of(input bit b, input logic [2:0] l);
    return b ? (1 << ((l > 3'd3) ? 3 : int'(l))) : 1;
  endfunction

  task automatic clear_inputs();
    m_read = '0; m_write = '0; m_addr = '0; m_burst = '0; m_burst_len = '0;
    m_wdata = '0; m_byteenable = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  // Tasks start and end at 1 time unit after a rising edge.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit wr, input bit rd, input logic [AW-1:0] a,
                         input bit b, input logic [2:0] l, input logic [DW-1:0] d,
                         input logic [1:0] be);
    m_write[i] = wr; m_read[i] = rd; m_addr[i*AW +: AW] = a; m_burst[i] = b;
    m_burst_len[i*3 +: 3] = l; m_wdata[i*DW +: DW] = d; m_byteenable[i*2 +: 2] = be;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus_read, bus_write, bus_addr, bus_burst, bus_burst_len, bus_wdata, bus_byteenable} !== '0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0",
        {bus_read, bus_write, bus_addr, bus_burst, bus_burst_len, bus_wdata, bus_byteenable});
    end
    checks++;
    if ({m_ready, m_rvalid} !== '0) begin
      errors++; $display("FAIL reset_handshake: got %b expected 0", {m_ready, m_rvalid});
    end
    checks++;
    if (owner !== '0 || stray_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_owner_stray: got %0d/%b expected 0/0", owner, stray_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(0, 1, 0, 24'h000010, 0, 3'd0, 16'hA5A5, 2'b11);
    for (int c = 0; c < 5; c++) begin
      bus_ready = (c == 3);
      if (c == 4) m_write[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_write !== (c >= 1 && c <= 3)) begin
        errors++; $display("FAIL single_wr_buswrite c=%0d: got %b expected %b", c, bus_write, (c >= 1 && c <= 3));
      end
      checks++;
      if (m_ready !== N'(c == 3)) begin
        errors++; $display("FAIL single_wr_ready c=%0d: got %b expected %b", c, m_ready, N'(c == 3));
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({bus_addr, bus_wdata, bus_byteenable, bus_read} !== {24'h000010, 16'hA5A5, 2'b11, 1'b0}) begin
          errors++; $display("FAIL single_wr_payload c=%0d: got %h/%h/%b/%b expected 000010/a5a5/11/0",
                             c, bus_addr, bus_wdata, bus_byteenable, bus_read);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    int got;
    got = 0;
    do_reset();
    set_req(0, 1, 0, 24'h000100, 0, 3'd0, 16'h0001, 2'b11);
    set_req(1, 1, 0, 24'h000200, 0, 3'd0, 16'h0002, 2'b11);
    bus_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (|m_ready) begin
        checks++;
        if (m_ready !== N'(1 << (got % 2))) begin
          errors++; $display("FAIL rr_grant #%0d: got %b expected %b", got, m_ready, N'(1 << (got % 2)));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got != 4) begin
      errors++; $display("FAIL rr_count: got %0d expected 4", got);
    end
  endtask

  task automatic test_burst_read();
    bit acc;
    acc = 1'b0;
    do_reset();
    set_req(1, 0, 1, 24'h000200, 1, 3'd2, 16'h0000, 2'b11);
    bus_ready = 1'b1;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      if (m_ready[1]) acc = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!acc) begin
      errors++; $display("FAIL bread_accept: got 0 expected 1");
    end
    m_read[1] = 1'b0;
    bus_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus_rvalid = 1'b1;
      bus_rdata  = DW'(16'h1111 * (b + 1));
      @(negedge clk);
      checks++;
      if (m_rvalid !== 3'b010 || m_rdata !== DW'(16'h1111 * (b + 1))) begin
        errors++; $display("FAIL bread_beat%0d: got %b/%h expected 010/%h", b, m_rvalid, m_rdata, DW'(16'h1111 * (b + 1)));
      end
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      if (b < 3) begin
        @(negedge clk);
        checks++;
        if (m_rvalid !== '0) begin
          errors++; $display("FAIL bread_gap%0d: got %b expected 000", b, m_rvalid);
        end
        @(posedge clk); #1;
      end
    end
    // A fresh write should show on the bus after exactly one idle cycle.
    set_req(0, 1, 0, 24'h000030, 0, 3'd0, 16'h0030, 2'b11);
    @(negedge clk);
    checks++;
    if (bus_write !== 1'b0) begin
      errors++; $display("FAIL bread_idle_after: got %b expected 0", bus_write);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_write !== 1'b1 || owner !== OW'(0)) begin
      errors++; $display("FAIL bread_next_grant: got %b/%0d expected 1/0", bus_write, owner);
    end
    @(posedge clk); #1;
    m_write[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (stray_rvalid !== 1'b0) begin
      errors++; $display("FAIL bread_stray: got %b expected 0", stray_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst_write_fair();
    int n0;
    n0 = 0;
    do_reset();
    set_req(0, 1, 0, 24'h000400, 1, 3'd3, 16'h0000, 2'b11);
    set_req(1, 0, 1, 24'h000500, 0, 3'd0, 16'h0000, 2'b11);
    for (int c = 0; c < 200 && n0 < 8; c++) begin
      bus_ready = 1'($urandom_range(0, 1));
      m_wdata[0 +: DW] = DW'(n0);
      @(negedge clk);
      checks++;
      if (m_ready[1] !== 1'b0 || bus_read !== 1'b0) begin
        errors++; $display("FAIL bwr_hold beat %0d: got ready1=%b read=%b expected 0/0", n0, m_ready[1], bus_read);
      end
      if (m_ready[0]) begin
        checks++;
        if (bus_wdata !== DW'(n0)) begin
          errors++; $display("FAIL bwr_wdata: got %h expected %h", bus_wdata, DW'(n0));
        end
        n0++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n0 != 8) begin
      errors++; $display("FAIL bwr_beats: got %0d expected 8", n0);
    end
    m_write[0] = 1'b0;
    bus_ready  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b0) begin
      errors++; $display("FAIL bwr_idle: got %b expected 0", bus_read);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b1 || owner !== OW'(1) || bus_addr !== 24'h000500) begin
      errors++; $display("FAIL bwr_m1_grant: got %b/%0d/%h expected 1/1/000500", bus_read, owner, bus_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stray();
    do_reset();
    bus_rvalid = 1'b1;
    bus_rdata  = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (m_rvalid !== '0) begin
      errors++; $display("FAIL stray_route: got %b expected 000", m_rvalid);
    end
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (stray_rvalid !== 1'b1) begin
        errors++; $display("FAIL stray_hold c=%0d: got %b expected 1", c, stray_rvalid);
      end
      @(posedge clk); #1;
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (stray_rvalid !== 1'b0) begin
      errors++; $display("FAIL stray_clear: got %b expected 0", stray_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 0, 1, 24'h000600, 1, 3'd2, 16'h0000, 2'b11);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m_ready !== 3'b001) begin
      errors++; $display("FAIL rmid_accept: got %b expected 001", m_ready);
    end
    @(posedge clk); #1;
    m_read[0] = 1'b0;
    bus_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus_rvalid = 1'b1;
      bus_rdata  = DW'(b + 7);
      @(negedge clk);
      checks++;
      if (m_rvalid !== 3'b001) begin
        errors++; $display("FAIL rmid_beat%0d: got %b expected 001", b, m_rvalid);
      end
      @(posedge clk); #1;
    end
    bus_rvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus_read, bus_write, bus_addr, bus_burst, bus_burst_len, bus_wdata, bus_byteenable,
         m_ready, m_rvalid, owner, stray_rvalid} !== '0) begin
      errors++; $display("FAIL rmid_outputs: got addr=%h rd=%b wr=%b ready=%b rvalid=%b owner=%0d expected all 0",
                         bus_addr, bus_read, bus_write, m_ready, m_rvalid, owner);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1, 0, 24'h000700, 0, 3'd0, 16'h0007, 2'b11);
    set_req(1, 1, 0, 24'h000800, 0, 3'd0, 16'h0008, 2'b11);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m_ready !== 3'b001 || owner !== OW'(0)) begin
      errors++; $display("FAIL rmid_first_grant: got %b/%0d expected 001/0", m_ready, owner);
    end
    @(posedge clk); #1;
  endtask

  // Transaction-level model: a grant goes to the first pending requester after the
  // previous winner; it lasts until all write beats are accepted or all read beats
  // returned, and exactly one quiet cycle separates consecutive transactions.
  task automatic test_random();
    bit            act[N];
    bit            wr[N];
    bit            bu[N];
    logic [AW-1:0] ad[N];
    logic [2:0]    ln[N];
    int            wleft[N];
    int            rleft[N];
    int            mlast, mo, busy_cyc, ctl_rd, done_tx, idx;
    bit            busy, first;
    logic [N-1:0]  mask;
    do_reset();
    mlast = N - 1; mo = 0; busy = 1'b0; first = 1'b0; busy_cyc = 0; ctl_rd = 0; done_tx = 0;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; wr[i] = 1'b0; bu[i] = 1'b0; ad[i] = '0; ln[i] = '0; wleft[i] = 0; rleft[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, act[i] & wr[i], act[i] & ~wr[i], ad[i], bu[i], ln[i],
                {ad[i][7:0], 8'(wleft[i])}, 2'(i + 1));
      end
      bus_ready  = 1'($urandom_range(0, 1));
      bus_rvalid = (ctl_rd > 0) && ($urandom_range(0, 2) != 0);
      bus_rdata  = DW'($urandom);
      @(negedge clk);
      if (!busy) begin
        checks++;
        if ({bus_read, bus_write, m_ready, m_rvalid} !== '0) begin
          errors++; $display("FAIL rnd_idle cyc=%0d: got rd=%b wr=%b ready=%b rvalid=%b expected all 0",
                             cyc, bus_read, bus_write, m_ready, m_rvalid);
        end
        for (int k = N; k >= 1; k--) begin
          idx = (mlast + k) % N;
          if (act[idx]) begin mo = idx; busy = 1'b1; end
        end
        if (busy) begin mlast = mo; first = 1'b1; busy_cyc = 0; end
      end else begin
        busy_cyc++;
        mask = N'(1) << mo;
        checks++;
        if (owner !== OW'(mo) || (m_ready & ~mask) !== '0 || (m_rvalid & ~mask) !== '0) begin
          errors++; $display("FAIL rnd_owner cyc=%0d: got owner=%0d ready=%b rvalid=%b expected owner=%0d",
                             cyc, owner, m_ready, m_rvalid, mo);
        end
        if (first) begin
          first = 1'b0;
          checks++;
          if ({bus_write, bus_read, bus_addr, bus_burst, bus_burst_len} !== {wr[mo], ~wr[mo], ad[mo], bu[mo], ln[mo]}) begin
            errors++; $display("FAIL rnd_cmd cyc=%0d: got wr=%b rd=%b addr=%h expected wr=%b addr=%h from m%0d",
                               cyc, bus_write, bus_read, bus_addr, wr[mo], ad[mo], mo);
          end
        end
        if (bus_write) begin
          checks++;
          if (bus_wdata !== {ad[mo][7:0], 8'(wleft[mo])}) begin
            errors++; $display("FAIL rnd_wdata cyc=%0d: got %h expected %h", cyc, bus_wdata, {ad[mo][7:0], 8'(wleft[mo])});
          end
        end
        if (m_ready[mo]) begin
          checks++;
          if (!act[mo]) begin
            errors++; $display("FAIL rnd_spurious_ready cyc=%0d: got 1 expected 0", cyc);
          end else if (wr[mo]) begin
            wleft[mo]--;
            if (wleft[mo] == 0) begin act[mo] = 1'b0; busy = 1'b0; done_tx++; end
          end else begin
            act[mo] = 1'b0;
            rleft[mo] = beats_of(bu[mo], ln[mo]);
          end
        end
        if (m_rvalid[mo]) begin
          checks++;
          if (m_rdata !== bus_rdata || rleft[mo] == 0) begin
            errors++; $display("FAIL rnd_rdata cyc=%0d: got %h left=%0d expected %h", cyc, m_rdata, rleft[mo], bus_rdata);
          end
          if (rleft[mo] > 0) rleft[mo]--;
          if (rleft[mo] == 0) begin busy = 1'b0; done_tx++; end
        end
        if (busy_cyc > 400) begin
          checks++; errors++;
          $display("FAIL rnd_timeout cyc=%0d: got still busy expected done within 400 cycles", cyc);
          break;
        end
      end
      if (bus_read && bus_ready) ctl_rd = beats_of(bus_burst, bus_burst_len);
      else if (bus_rvalid) ctl_rd--;
      for (int i = 0; i < N; i++) begin
        if (!act[i] && rleft[i] == 0 && $urandom_range(0, 3) == 0) begin
          act[i]   = 1'b1;
          wr[i]    = 1'($urandom_range(0, 1));
          ad[i]    = AW'($urandom);
          bu[i]    = 1'($urandom_range(0, 1));
          ln[i]    = 3'($urandom_range(0, 7));
          wleft[i] = wr[i] ? beats_of(bu[i], ln[i]) : 0;
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_tx < 20) begin
      errors++; $display("FAIL rnd_progress: got %0d transactions expected at least 20", done_tx);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst_read();
    test_burst_write_fair();
    test_stray();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
